tiny_rv_mdu: RTL and testbench
==============================

# tiny_rv_mdu

Parametrised multi-cycle multiply/divide unit implementing the RV32M extension for the tiny_rv core execute stage. It sits beside the single-cycle integer ALU and takes R-type operations with `funct7 = 7'b0000001`. Operands are accepted over a valid/ready handshake, computed iteratively at `UNROLL` bits per cycle, and returned over a second valid/ready handshake. Divide corner cases (divide by zero, signed overflow) complete on a fast path.

## Interface
- `XLEN`, 32, operand/result width; must be ≥ 8 and even.
- `UNROLL`, 1, bits processed per iteration cycle; must divide `XLEN` (1, 2, 4 legal).
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_valid`  in  1  request valid.
- `o_ready`  out  1  unit can accept a request.
- `i_funct3`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_rs1`, `i_rs2`  in  XLEN  operands (rs1 = multiplicand/dividend).
- `i_kill`  in  1  pipeline flush; aborts any in-flight op.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts result.
- `o_result`  out  XLEN  result.
- `o_busy`  out  1  high in CALC or DONE (stall hint for the hazard unit).

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: `o_ready=1`. On `i_valid && !i_kill`, latch funct3, operands, and the operand signs. Go to CALC, or to DONE for a fast-path case.
- Fast path, DIV/DIVU/REM/REMU only:
  - rs2 == 0: quotient = all ones; remainder = rs1.
  - DIV/REM with rs1 = most-negative and rs2 = −1: quotient = rs1; remainder = 0.
- Multiply:
  - Operands are converted to magnitudes according to signedness (MULH both signed, MULHSU rs1 only, MULHU/MUL neither needed).
  - Shift-add over a 2·XLEN accumulator, `UNROLL` multiplier bits per cycle.
  - Final result is negated if the sign product is negative.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes, `UNROLL` quotient bits per cycle.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
  - Results obey RISC-V truncation semantics.
- CALC: an iteration counter counts 0 → XLEN/UNROLL−1. On the last count, register the sign-corrected result and go to DONE.
- DONE: `o_valid=1`; `o_result` is held stable. On `i_ready`, return to IDLE.
- `i_kill` in CALC or DONE: go to IDLE next cycle, drop `o_valid`, discard the result. `i_kill` in IDLE blocks acceptance that cycle.
- Arithmetic is unsigned internally at XLEN+1 / 2·XLEN width. No `$signed` compares on state registers.

## Timing
- Reset values: state IDLE, `o_ready=1`, `o_valid=0`, `o_busy=0`, `o_result=0`, counter 0.
- Normal latency:
  - Accept edge → `o_valid` high after XLEN/UNROLL + 1 cycles.
  - 33 cycles at the defaults.
- Fast-path latency: `o_valid` high on the cycle after accept.
- `o_ready` is low throughout CALC and DONE. There is no accept in the same cycle as result retirement; the next accept is one cycle after the `i_ready` handshake.
- Backpressure: DONE is held indefinitely with `o_result` unchanged while `i_ready=0`.
- An `i_rst` assertion at any point forces all outputs to their reset values immediately. There is no partial result after reset.
- `i_kill` and `i_ready` asserted together in DONE: kill wins; the result is not counted as consumed.

## Structure
- Shared package `tiny_rv_pkg` holds:
  - M-extension funct3 localparams (`RV_MD_MUL` … `RV_MD_REMU`).
  - `RV_FUNCT7_MULDIV = 7'b0000001`.
  - The state enum `mdu_state_t`.
- Sub-module `tiny_rv_div_step`: a combinational single restoring-division step, instantiated `UNROLL` times in a chain. Multiply steps stay inline.
- Decode of opcode/funct7 stays in the decoder. This block sees only funct3 plus the handshake.

## Test plan
- MUL with rs1=7, rs2=0xFFFFFFFD (−3) → `o_result=0xFFFFFFEB` after 33 cycles; then MULHU with 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH with 0x80000000×0x80000000 → 0x40000000; MULHSU with 0xFFFFFFFF (−1) × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV with 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM on the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Fast path:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
  - Each has `o_valid` 1 cycle after accept.
- Backpressure and kill:
  - Hold `i_ready=0` for 10 cycles in DONE → `o_result` stable, `o_ready=0`.
  - Assert `i_kill` at CALC cycle 5 → IDLE next cycle, no `o_valid`. A following MUL 3×4 → 12.
- Reset mid-CALC and `UNROLL=4` build:
  - Async `i_rst` asserted → outputs return to reset values without a clock edge.
  - Rerun scenarios 1–3 with `UNROLL=4` → identical results, latency 9 cycles.

Source files
------------

// File: rtl/tiny_rv_pkg.sv
// Shared definitions for the tiny_rv core: M-extension funct3 codes, the
// MUL/DIV funct7 value and the multiply/divide unit state encoding.
package tiny_rv_pkg;

  localparam logic [6:0] RV_FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] RV_MD_MUL    = 3'b000;
  localparam logic [2:0] RV_MD_MULH   = 3'b001;
  localparam logic [2:0] RV_MD_MULHSU = 3'b010;
  localparam logic [2:0] RV_MD_MULHU  = 3'b011;
  localparam logic [2:0] RV_MD_DIV    = 3'b100;
  localparam logic [2:0] RV_MD_DIVU   = 3'b101;
  localparam logic [2:0] RV_MD_REM    = 3'b110;
  localparam logic [2:0] RV_MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } mdu_state_t;

  // Divide/remainder ops all have funct3[2] set.
  function automatic logic md_is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  // Remainder ops (REM/REMU) have funct3[1] set within the divide group.
  function automatic logic md_is_rem(input logic [2:0] funct3);
    return funct3[2] & funct3[1];
  endfunction

endpackage

// File: rtl/tiny_rv_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_i  partial remainder (always < div_i)
//   quo_i  dividend/quotient shift register; its MSB is the next dividend bit
//   div_i  divisor magnitude
//   rem_o  updated partial remainder
//   quo_o  quo_i shifted left with the new quotient bit in the LSB
module tiny_rv_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Since rem_i < div_i, shifted < 2*div_i: a non-negative difference fits in
  // XLEN bits, so the top bit of diff is a clean borrow flag.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {1'b0, div_i};

  always_comb begin
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/tiny_rv_mdu.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring
// divide on operand magnitudes, UNROLL bits per cycle, with sign correction
// at the end and a one-cycle fast path for divide-by-zero and signed overflow.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_valid/o_ready         request handshake (i_funct3, i_rs1, i_rs2)
//   i_kill                  flush: aborts any in-flight op, blocks accept
//   o_valid/i_ready         result handshake (o_result held while waiting)
//   o_busy                  high while an op is in CALC or DONE
module tiny_rv_mdu
  import tiny_rv_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int unsigned Steps = XLEN / UNROLL;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);
  localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;      // multiplicand / divisor magnitude
  logic [2*XLEN-1:0] acc_q, acc_d;          // {hi, lo}: product or {rem, quo}
  logic              quo_neg_q, quo_neg_d;  // negate product / quotient
  logic              rem_neg_q, rem_neg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Request decode and operand conditioning.
  logic            accept;
  logic            rs1_signed, rs2_signed, rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            fast_zero, fast_ovf, fast;
  logic [XLEN-1:0] fast_result;

  assign accept     = i_valid && !i_kill;
  assign rs1_signed = (i_funct3 == RV_MD_MULH) || (i_funct3 == RV_MD_MULHSU) ||
                      (i_funct3 == RV_MD_DIV)  || (i_funct3 == RV_MD_REM);
  assign rs2_signed = (i_funct3 == RV_MD_MULH) || (i_funct3 == RV_MD_DIV) ||
                      (i_funct3 == RV_MD_REM);
  assign rs1_neg    = rs1_signed && i_rs1[XLEN-1];
  assign rs2_neg    = rs2_signed && i_rs2[XLEN-1];
  assign rs1_mag    = rs1_neg ? -i_rs1 : i_rs1;
  assign rs2_mag    = rs2_neg ? -i_rs2 : i_rs2;

  assign fast_zero  = md_is_div(i_funct3) && (i_rs2 == '0);
  assign fast_ovf   = md_is_div(i_funct3) && !i_funct3[0] && (i_rs1 == MostNeg) &&
                      (i_rs2 == '1);
  assign fast       = fast_zero || fast_ovf;

  always_comb begin
    if (md_is_rem(i_funct3)) begin
      fast_result = fast_zero ? i_rs1 : '0;
    end else begin
      fast_result = fast_zero ? '1 : i_rs1;
    end
  end

  // Multiply: UNROLL shift-add steps, multiplier bits consumed from the LSB.
  logic [2*XLEN-1:0] mul_acc;
  logic [XLEN:0]     mul_sum;

  always_comb begin
    mul_acc = acc_q;
    mul_sum = '0;
    for (int i = 0; i < UNROLL; i++) begin
      mul_sum = {1'b0, mul_acc[2*XLEN-1:XLEN]} + (mul_acc[0] ? {1'b0, mcand_q} : '0);
      mul_acc = {mul_sum, mul_acc[XLEN-1:1]};
    end
  end

  // Divide: chain of UNROLL restoring steps.
  logic [XLEN-1:0] rem_chain [UNROLL+1];
  logic [XLEN-1:0] quo_chain [UNROLL+1];

  assign rem_chain[0] = acc_q[2*XLEN-1:XLEN];
  assign quo_chain[0] = acc_q[XLEN-1:0];

  for (genvar g = 0; g < UNROLL; g++) begin : g_div
    tiny_rv_div_step #(
      .XLEN(XLEN)
    ) u_step (
      .rem_i(rem_chain[g]),
      .quo_i(quo_chain[g]),
      .div_i(mcand_q),
      .rem_o(rem_chain[g+1]),
      .quo_o(quo_chain[g+1])
    );
  end

  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

  assign acc_nxt = md_is_div(funct3_q) ? {rem_chain[UNROLL], quo_chain[UNROLL]} : mul_acc;
  assign prod    = quo_neg_q ? -acc_nxt : acc_nxt;
  assign quo_fix = quo_neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
  assign rem_fix = rem_neg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    if (md_is_div(funct3_q)) begin
      final_result = funct3_q[1] ? rem_fix : quo_fix;
    end else if (funct3_q == RV_MD_MUL) begin
      final_result = prod[XLEN-1:0];
    end else begin
      final_result = prod[2*XLEN-1:XLEN];
    end
  end

  // FSM: state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = fast ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (i_kill) begin
          state_d = StIdle;
        end else if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Kill and ready together both land in IDLE; the result counts as dropped.
        if (i_kill || i_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    o_ready  = (state_q == StIdle);
    o_valid  = (state_q == StDone);
    o_busy   = (state_q == StCalc) || (state_q == StDone);
    o_result = result_q;
  end

  // Datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      funct3_q  <= RV_MD_MUL;
      mcand_q   <= '0;
      acc_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      funct3_q  <= funct3_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    funct3_d  = funct3_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          funct3_d  = i_funct3;
          mcand_d   = rs2_mag;
          acc_d     = {{XLEN{1'b0}}, rs1_mag};
          quo_neg_d = rs1_neg ^ rs2_neg;
          rem_neg_d = rs1_neg;
          cnt_d     = '0;
          if (fast) begin
            result_d = fast_result;
          end
        end
      end
      StCalc: begin
        if (i_kill) begin
          cnt_d = '0;
        end else begin
          acc_d = acc_nxt;
          if (cnt_q == LastCnt) begin
            cnt_d    = '0;
            result_d = final_result;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tiny_rv_mdu.sv
module tb_tiny_rv_mdu;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          fast;
  } op_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_kill, i_ready;
  logic [2:0]  i_funct3;
  logic [31:0] i_rs1, i_rs2;
  bit          sel4 = 1'b0;

  logic        rdy1, vld1, busy1, rdy4, vld4, busy4;
  logic [31:0] res1, res4;
  logic        o_ready, o_valid, o_busy;
  logic [31:0] o_result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  tiny_rv_mdu #(.XLEN(32), .UNROLL(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid && !sel4), .o_ready(rdy1),
    .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_kill(i_kill),
    .o_valid(vld1), .i_ready(i_ready), .o_result(res1), .o_busy(busy1)
  );

  tiny_rv_mdu #(.XLEN(32), .UNROLL(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid && sel4), .o_ready(rdy4),
    .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_kill(i_kill),
    .o_valid(vld4), .i_ready(i_ready), .o_result(res4), .o_busy(busy4)
  );

  assign o_ready  = sel4 ? rdy4 : rdy1;
  assign o_valid  = sel4 ? vld4 : vld1;
  assign o_busy   = sel4 ? busy4 : busy1;
  assign o_result = sel4 ? res4 : res1;

  function automatic int norm_lat();
    return (sel4 ? 8 : 32) + 1;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = $signed(a);
    sb  = $signed(b);
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit to);
    int k = 0;
    while (!o_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    i_funct3 = f3; i_rs1 = a; i_rs2 = b; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    to  = !o_valid;
    res = o_result;
  endtask

  task automatic run_op(input op_t op, output logic [31:0] res, output int lat,
                        output bit to);
    exp_q.push_back(op.exp);
    issue(op.f3, op.a, op.b, res, lat, to);
  endtask

  task automatic retire();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_ops(input string tag, input op_t ops[$]);
    logic [31:0] res, exp;
    int          lat, elat;
    bit          to;
    foreach (ops[i]) begin
      run_op(ops[i], res, lat, to);
      exp  = exp_q.pop_front();
      elat = ops[i].fast ? 1 : norm_lat();
      n_tests++;
      if (to || res !== exp) begin
        n_fail++;
        $display("FAIL %s[%0d] u%0d f3=%0d a=%h b=%h: got %h (timeout=%0d) expected %h",
                 tag, i, sel4 ? 4 : 1, ops[i].f3, ops[i].a, ops[i].b, res, to, exp);
      end
      n_tests++;
      if (lat !== elat) begin
        n_fail++;
        $display("FAIL %s_latency[%0d] u%0d: got %0d expected %0d", tag, i, sel4 ? 4 : 1,
                 lat, elat);
      end
      retire();
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({o_ready, o_valid, o_busy} !== 3'b100 || o_result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: ready/valid/busy=%b result=%h expected 100 / 0",
               {o_ready, o_valid, o_busy}, o_result);
    end
  endtask

  task automatic test_mul();
    op_t ops[$];
    ops.push_back('{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
    ops.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
    ops.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0});
    ops.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
    test_ops("mul", ops);
  endtask

  task automatic test_div();
    op_t ops[$];
    ops.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0});
    ops.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0});
    ops.push_back('{3'd5, 32'd100, 32'd7, 32'd14, 1'b0});
    ops.push_back('{3'd7, 32'd100, 32'd7, 32'd2, 1'b0});
    test_ops("div", ops);
  endtask

  task automatic test_fast_path();
    op_t ops[$];
    ops.push_back('{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1});
    ops.push_back('{3'd7, 32'd5, 32'd0, 32'd5, 1'b1});
    ops.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    ops.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1});
    test_ops("fast", ops);
  endtask

  task automatic test_random();
    op_t         ops[$];
    logic [31:0] a, b;
    logic [2:0]  f3;
    for (int i = 0; i < 16; i++) begin
      f3 = 3'(i % 8);
      a  = $urandom;
      b  = (i % 5 == 4) ? 32'h0 : (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      ops.push_back('{f3, a, b, model(f3, a, b),
                      f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == '1))});
    end
    test_ops("rand", ops);
  endtask

  task automatic test_backpressure();
    logic [31:0] res, exp;
    int          lat;
    bit          to, ok;
    run_op('{3'd0, 32'd5, 32'd6, 32'd30, 1'b0}, res, lat, to);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || res !== exp) begin
      n_fail++;
      $display("FAIL bp_result: got %h (timeout=%0d) expected %h", res, to, exp);
    end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (o_result !== exp || !o_valid || o_ready !== 1'b0) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_hold: result=%h valid=%b ready=%b expected %h/1/0", o_result,
               o_valid, o_ready, exp);
    end
    retire();
  endtask

  task automatic test_kill();
    logic [31:0] res, exp;
    int          lat, vseen;
    bit          to;
    // Kill in IDLE blocks acceptance.
    i_funct3 = 3'd0; i_rs1 = 32'd9; i_rs2 = 32'd9; i_valid = 1'b1; i_kill = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_kill = 1'b0;
    n_tests++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_idle: busy=%b ready=%b expected 0/1", o_busy, o_ready);
    end
    // Kill at CALC cycle 5.
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    i_kill = 1'b1;
    @(posedge clk); #1;
    i_kill = 1'b0;
    n_tests++;
    if ({o_ready, o_valid, o_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL kill_calc: ready/valid/busy=%b expected 100", {o_ready, o_valid, o_busy});
    end
    vseen = 0;
    repeat (40) begin @(posedge clk); #1; if (o_valid) vseen++; end
    n_tests++;
    if (vseen != 0) begin
      n_fail++;
      $display("FAIL kill_no_valid: o_valid seen %0d cycles expected 0", vseen);
    end
    run_op('{3'd0, 32'd3, 32'd4, 32'd12, 1'b0}, res, lat, to);
    exp = exp_q.pop_front();
    n_tests++;
    if (to || res !== exp) begin
      n_fail++;
      $display("FAIL kill_then_mul: got %h (timeout=%0d) expected %h", res, to, exp);
    end
    // Kill and ready together in DONE: kill wins.
    i_kill = 1'b1;
    retire();
    i_kill = 1'b0;
    n_tests++;
    if ({o_ready, o_valid, o_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL kill_done: ready/valid/busy=%b expected 100", {o_ready, o_valid, o_busy});
    end
  endtask

  task automatic test_async_reset();
    i_funct3 = 3'd0; i_rs1 = 32'd7; i_rs2 = 32'hFFFF_FFFD; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({o_ready, o_valid, o_busy} !== 3'b100 || o_result !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: ready/valid/busy=%b result=%h expected 100 / 0",
               {o_ready, o_valid, o_busy}, o_result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_kill = 1'b0; i_ready = 1'b0;
    i_funct3 = 3'd0; i_rs1 = '0; i_rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_backpressure();
    test_kill();
    test_random();
    test_async_reset();
    sel4 = 1'b1;
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
